// File: rtl/lab3_mem_cache_assoc_dpath.sv
// Datapath of a 1/2-way set-associative blocking cache with 16B lines and an optional bank field.
// Define LAB3_MEM_CACHE_ASSOC_LRU_EN for a per-set LRU bit; otherwise a global toggle picks the victim.

package lab3_mem_msgs_pkg;

  typedef struct packed {
    logic [3:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [3:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  typedef struct packed {
    logic [3:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [3:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

module lab3_mem_cache_assoc_dpath
  import lab3_mem_msgs_pkg::*;
#(
  parameter int p_num_sets  = 16,
  parameter int p_num_ways  = 2,
  parameter int p_num_banks = 1
) (
  input  logic          clk,
  input  logic          reset,

  input  mem_req_4B_t   proc2cache_reqstream_msg,
  output mem_resp_4B_t  proc2cache_respstream_msg,
  output mem_req_16B_t  cache2mem_reqstream_msg,
  input  mem_resp_16B_t cache2mem_respstream_msg,

  input  logic          cachereq_reg_en,
  input  logic          memresp_reg_en,
  input  logic          write_data_mux_sel,
  input  logic          wben_mux_sel,
  input  logic          tag_array_wen,
  input  logic          tag_array_ren,
  input  logic          data_array_wen,
  input  logic          data_array_ren,
  input  logic          read_data_zero_mux_sel,
  input  logic          read_data_reg_en,
  input  logic          evict_addr_reg_en,
  input  logic          memreq_addr_mux_sel,
  input  logic          way_reg_en,
  input  logic          valid_wen,
  input  logic          dirty_wen,
  input  logic          dirty_in,
  input  logic          lru_upd_en,
  input  logic [1:0]    hit,
  input  logic [3:0]    memreq_type,

  output logic [3:0]    cachereq_type,
  output logic [31:0]   cachereq_addr,
  output logic          tag_match,
  output logic          hit_way,
  output logic          victim_dirty,
  output logic          way_reg
);

  localparam int IDX_W  = $clog2(p_num_sets);
  localparam int BANK_W = (p_num_banks == 4) ? 2 : 0;
  localparam int LO     = 4 + BANK_W + IDX_W;
  localparam int TAG_W  = 32 - LO;

  logic [3:0]   type_q, type_d;
  logic [31:0]  addr_q, addr_d;
  logic [7:0]   opaque_q, opaque_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [127:0] memresp_q, memresp_d;
  logic [127:0] read_data_q, read_data_d;
  logic [31:0]  evict_addr_q, evict_addr_d;
  logic         way_reg_q, way_reg_d;

  logic [p_num_sets-1:0] valid_q [p_num_ways];
  logic [p_num_sets-1:0] valid_d [p_num_ways];
  logic [p_num_sets-1:0] dirty_q [p_num_ways];
  logic [p_num_sets-1:0] dirty_d [p_num_ways];

  logic [TAG_W-1:0] tag_mem  [p_num_ways][p_num_sets];
  logic [127:0]     data_mem [p_num_ways][p_num_sets];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       word_off;
  logic             way_sel;
  logic [TAG_W-1:0] tag_rd;
  logic [127:0]     line_rd;
  logic [127:0]     wr_line;
  logic [15:0]      wr_ben;
  logic [1:0]       way_match;
  logic [1:0]       way_vld;
  logic [1:0]       way_dirty;
  logic             victim;
  logic             policy_victim;

  assign idx      = addr_q[4+BANK_W +: IDX_W];
  assign req_tag  = addr_q[31:LO];
  assign word_off = addr_q[3:2];
  // A direct-mapped build only ever owns way 0.
  assign way_sel  = (p_num_ways == 2) ? way_reg_q : 1'b0;
  assign tag_rd   = tag_mem[way_sel][idx];
  assign line_rd  = data_mem[way_sel][idx];

  for (genvar w = 0; w < 2; w++) begin : g_way
    if (w < p_num_ways) begin : g_on
      assign way_vld[w]   = valid_q[w][idx];
      assign way_dirty[w] = dirty_q[w][idx];
      assign way_match[w] = valid_q[w][idx] && (tag_mem[w][idx] == req_tag);
    end else begin : g_off
      assign way_vld[w]   = 1'b0;
      assign way_dirty[w] = 1'b0;
      assign way_match[w] = 1'b0;
    end
  end

  assign tag_match = |way_match;
  assign hit_way   = ~way_match[0] & way_match[1];

  always_comb begin
    victim = 1'b0;
    if (p_num_ways == 2) begin
      if (!way_vld[0])      victim = 1'b0;
      else if (!way_vld[1]) victim = 1'b1;
      else                  victim = policy_victim;
    end
  end

  assign victim_dirty = way_dirty[victim];

`ifdef LAB3_MEM_CACHE_ASSOC_LRU_EN
  // One bit per set holding the most-recently-used way; the other way is evicted.
  logic [p_num_sets-1:0] mru_q, mru_d;

  always_comb begin
    mru_d = mru_q;
    if (lru_upd_en && (p_num_ways == 2)) mru_d[idx] = way_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) mru_q <= '0;
    else       mru_q <= mru_d;
  end

  assign policy_victim = ~mru_q[idx];
`else
  logic repl_tgl_q, repl_tgl_d;
  logic unused_lru;

  assign repl_tgl_d = valid_wen ? ~repl_tgl_q : repl_tgl_q;

  always_ff @(posedge clk) begin
    if (reset) repl_tgl_q <= 1'b0;
    else       repl_tgl_q <= repl_tgl_d;
  end

  assign policy_victim = repl_tgl_q;
  assign unused_lru    = lru_upd_en;
`endif

  always_comb begin
    wr_line = memresp_q;
    wr_ben  = 16'hFFFF;
    if (write_data_mux_sel) begin
      wr_line = {4{wdata_q}};
      if (wben_mux_sel) wr_ben = 16'h000F << {word_off, 2'b00};
    end
  end

  // Arrays are not reset; writes are still blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (tag_array_wen) tag_mem[way_sel][idx] <= req_tag;
      if (data_array_wen) begin
        for (int b = 0; b < 16; b++) begin
          if (wr_ben[b]) data_mem[way_sel][idx][b*8 +: 8] <= wr_line[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    type_d       = type_q;
    addr_d       = addr_q;
    opaque_d     = opaque_q;
    wdata_d      = wdata_q;
    memresp_d    = memresp_q;
    read_data_d  = read_data_q;
    evict_addr_d = evict_addr_q;
    way_reg_d    = way_reg_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;

    if (cachereq_reg_en) begin
      type_d   = proc2cache_reqstream_msg.type_;
      addr_d   = proc2cache_reqstream_msg.addr;
      opaque_d = proc2cache_reqstream_msg.opaque;
      wdata_d  = proc2cache_reqstream_msg.data;
    end
    if (memresp_reg_en)    memresp_d    = cache2mem_respstream_msg.data;
    if (read_data_reg_en)  read_data_d  = read_data_zero_mux_sel ? line_rd : 128'h0;
    if (evict_addr_reg_en) evict_addr_d = {tag_rd, addr_q[LO-1:4], 4'b0000};
    if (way_reg_en)        way_reg_d    = tag_match ? hit_way : victim;
    if (valid_wen)         valid_d[way_sel][idx] = 1'b1;
    if (dirty_wen)         dirty_d[way_sel][idx] = dirty_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      type_q       <= '0;
      addr_q       <= '0;
      opaque_q     <= '0;
      wdata_q      <= '0;
      memresp_q    <= '0;
      read_data_q  <= '0;
      evict_addr_q <= '0;
      way_reg_q    <= 1'b0;
      for (int w = 0; w < p_num_ways; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      type_q       <= type_d;
      addr_q       <= addr_d;
      opaque_q     <= opaque_d;
      wdata_q      <= wdata_d;
      memresp_q    <= memresp_d;
      read_data_q  <= read_data_d;
      evict_addr_q <= evict_addr_d;
      way_reg_q    <= way_reg_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  always_comb begin
    proc2cache_respstream_msg        = '0;
    proc2cache_respstream_msg.type_  = type_q;
    proc2cache_respstream_msg.opaque = opaque_q;
    proc2cache_respstream_msg.test   = hit;
    proc2cache_respstream_msg.len    = 2'b00;
    proc2cache_respstream_msg.data   = read_data_q[{word_off, 5'b00000} +: 32];
  end

  always_comb begin
    cache2mem_reqstream_msg        = '0;
    cache2mem_reqstream_msg.type_  = memreq_type;
    cache2mem_reqstream_msg.opaque = 8'h00;
    cache2mem_reqstream_msg.addr   = memreq_addr_mux_sel ? evict_addr_q : {addr_q[31:4], 4'b0000};
    cache2mem_reqstream_msg.len    = 4'h0;
    cache2mem_reqstream_msg.data   = read_data_q;
  end

  assign cachereq_type = type_q;
  assign cachereq_addr = addr_q;
  assign way_reg       = way_reg_q;

  // Arrays are read combinationally every cycle, so the read enables carry no information here.
  logic unused_ok;
  assign unused_ok = &{1'b0, proc2cache_reqstream_msg.len, cache2mem_respstream_msg.type_,
                       cache2mem_respstream_msg.opaque, cache2mem_respstream_msg.test,
                       cache2mem_respstream_msg.len, tag_array_ren, data_array_ren};

endmodule
